// File: rtl/panel_ctrl_fsm_if.sv
// Board-side bundle of the front-panel controller: raw buttons and halt in,
// debounced pulses, CPU clock-enable, panel LEDs and a state debug tap out.
interface panel_ctrl_fsm_if #(
    parameter int N_BTN  = 4,
    parameter int STEP_W = 4
);
    logic [N_BTN-1:0]  button;
    logic              halt_req;
    logic [N_BTN-1:0]  btn_pulse;
    logic              cpu_en;
    logic              led_run_status;
    logic              led_idle;
    logic [STEP_W-1:0] led_run_step;
    logic [1:0]        dbg_state;

    // master: board/CPU side driving the panel; slave: the controller itself.
    modport master (
        output button, halt_req,
        input  btn_pulse, cpu_en, led_run_status, led_idle, led_run_step, dbg_state
    );

    modport slave (
        input  button, halt_req,
        output btn_pulse, cpu_en, led_run_status, led_idle, led_run_step, dbg_state
    );
endinterface

// File: rtl/panel_ctrl_fsm.sv
// MIC-1 front-panel controller: N debounced buttons driving an IDLE/RUN/STEP/BURST
// clock-enable FSM. Define PANEL_CTRL_BURST_EN to build in the BURST state and button[2].
module panel_ctrl_fsm #(
    parameter int N_BTN     = 4,
    parameter int DEB_W     = 4,
    parameter int STEP_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            resetn,
    panel_ctrl_fsm_if.slave pif
);

    if (N_BTN < 4) begin : g_chk_n_btn
        $error("panel_ctrl_fsm: N_BTN must be at least 4");
    end
    if (DEB_W < 1 || STEP_W < 1) begin : g_chk_widths
        $error("panel_ctrl_fsm: DEB_W and STEP_W must be at least 1");
    end
    if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_chk_burst_len
        $error("panel_ctrl_fsm: BURST_LEN must be in 1..65535");
    end

`ifdef PANEL_CTRL_BURST_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam logic [15:0] BURST_LOAD = 16'(BURST_LEN - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Debounce: 2-FF synchroniser, mismatch counter and accepted level.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] stable_q;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] pulse_d;
    logic [DEB_W-1:0] cnt_q [N_BTN];
    logic [DEB_W-1:0] cnt_d [N_BTN];

    // The level flips on the mismatching edge that finds the counter saturated,
    // and the pulse register is loaded on that same edge.
    always_comb begin
        stable_d = stable_q;
        pulse_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (&cnt_q[i]) begin
                    stable_d[i] = ~stable_q[i];
                    pulse_d[i]  = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= pif.button;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Run/step/burst FSM and executed-step counter.
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic              cpu_en;
    logic              run_p;
    logic              step_p;
    logic              clr_p;

    assign run_p  = pulse_q[0];
    assign step_p = pulse_q[1];
    assign clr_p  = pulse_q[3];

`ifdef PANEL_CTRL_BURST_EN
    logic        burst_p;
    logic [15:0] burst_cnt_q;

    assign burst_p = pulse_q[2];
`endif

    // Halt must gate the enable within the cycle it is raised, so this is not registered.
    assign cpu_en = (state_q != ST_IDLE) && !pif.halt_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
`ifdef PANEL_CTRL_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            if (clr_p) begin
                step_q <= '0;
            end else if (cpu_en) begin
                step_q <= step_q + 1'b1;
            end

            case (state_q)
                // A clear pulse in IDLE outranks any start request arriving with it.
                ST_IDLE: begin
                    if (!clr_p && !pif.halt_req) begin
                        if (run_p) begin
                            state_q <= ST_RUN;
                        end else if (step_p) begin
                            state_q <= ST_STEP;
                        end
`ifdef PANEL_CTRL_BURST_EN
                        else if (burst_p) begin
                            state_q     <= ST_BURST;
                            burst_cnt_q <= BURST_LOAD;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (clr_p || run_p || pif.halt_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_IDLE;
                end
`ifdef PANEL_CTRL_BURST_EN
                ST_BURST: begin
                    if (clr_p || pif.halt_req) begin
                        state_q <= ST_IDLE;
                    end else if (burst_cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        burst_cnt_q <= burst_cnt_q - 16'd1;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pif.btn_pulse    = pulse_q;
    assign pif.cpu_en       = cpu_en;
    assign pif.led_idle     = (state_q == ST_IDLE);
    assign pif.led_run_step = step_q;
    assign pif.dbg_state    = state_q;
`ifdef PANEL_CTRL_BURST_EN
    assign pif.led_run_status = (state_q == ST_RUN) || (state_q == ST_BURST);
`else
    assign pif.led_run_status = (state_q == ST_RUN);
`endif

endmodule

// File: tb/tb_panel_ctrl_fsm.sv
// Bench for panel_ctrl_fsm: directed panel scenarios plus random button traffic,
// checked every cycle against a sample-stream / mode-level reference model.
module tb_panel_ctrl_fsm;
    localparam int N_BTN     = 5;
    localparam int DEB_W     = 4;
    localparam int STEP_W    = 4;
    localparam int BURST_LEN = 4;
    localparam int DEB_N     = 1 << DEB_W;
    localparam int STEP_MOD  = 1 << STEP_W;
`ifdef PANEL_CTRL_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    panel_ctrl_fsm_if #(.N_BTN(N_BTN), .STEP_W(STEP_W)) pif ();

    panel_ctrl_fsm #(
        .N_BTN    (N_BTN),
        .DEB_W    (DEB_W),
        .STEP_W   (STEP_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .pif   (pif)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_STEP, M_BURST} mode_t;

    mode_t            m_mode;
    int               m_left;
    int               m_step;
    int               cyc;
    bit [N_BTN-1:0]   m_pulse;
    bit               run_val [N_BTN];
    bit               level   [N_BTN];
    int               run_len [N_BTN];
    int               pulse_at[N_BTN];

    logic             halt_v;
    int               n_checks;
    int               n_errors;
    int               en_cycles;
    int               pulse_seen [N_BTN];
    int               first_pulse[N_BTN];
    logic [STEP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_left  = 0;
        m_step  = 0;
        m_pulse = '0;
        for (int c = 0; c < N_BTN; c++) begin
            run_val[c]  = 1'b0;
            level[c]    = 1'b0;
            run_len[c]  = 0;
            pulse_at[c] = -100;
        end
    endfunction

    function automatic void clear_obs();
        for (int c = 0; c < N_BTN; c++) begin
            pulse_seen[c]  = 0;
            first_pulse[c] = -1;
        end
    endfunction

    // One clock edge of the panel: the FSM acts on the pulses visible before the
    // edge; a button level is accepted after DEB_N identical samples and its rising
    // pulse becomes visible two edges after the last of those samples.
    task automatic model_edge(input logic [N_BTN-1:0] b, input logic h);
        bit en, clr, run, stp, bst;
        en  = (m_mode != M_IDLE) && !h;
        clr = m_pulse[3];
        run = m_pulse[0];
        stp = m_pulse[1];
        bst = m_pulse[2] && BURST_ON;
        if (clr) m_step = 0;
        else if (en) m_step = (m_step + 1) % STEP_MOD;
        case (m_mode)
            M_IDLE: begin
                if (!clr && !h) begin
                    if (run) m_mode = M_RUN;
                    else if (stp) m_mode = M_STEP;
                    else if (bst) begin
                        m_mode = M_BURST;
                        m_left = BURST_LEN;
                    end
                end
            end
            M_RUN:  if (clr || run || h) m_mode = M_IDLE;
            M_STEP: m_mode = M_IDLE;
            M_BURST: begin
                if (clr || h) m_mode = M_IDLE;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        cyc++;
        for (int c = 0; c < N_BTN; c++) begin
            if (bit'(b[c]) == run_val[c]) begin
                if (run_len[c] <= DEB_N) run_len[c]++;
            end else begin
                run_val[c] = bit'(b[c]);
                run_len[c] = 1;
            end
            if (run_val[c] != level[c] && run_len[c] >= DEB_N) begin
                level[c] = run_val[c];
                if (level[c]) pulse_at[c] = cyc + 2;
            end
            m_pulse[c] = (pulse_at[c] == cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [N_BTN-1:0] b);
        pif.button   = b;
        pif.halt_req = halt_v;
        #1;
        check("cpu_en", 32'(pif.cpu_en), 32'((m_mode != M_IDLE) && !halt_v));
        if (pif.cpu_en === 1'b1) en_cycles++;
        @(posedge clk);
        model_edge(b, halt_v);
        #1;
        check("led_idle", 32'(pif.led_idle), 32'(m_mode == M_IDLE));
        check("led_run_status", 32'(pif.led_run_status), 32'(m_mode == M_RUN || m_mode == M_BURST));
        check("led_run_step", 32'(pif.led_run_step), 32'(m_step));
        check("btn_pulse", 32'(pif.btn_pulse), 32'(m_pulse));
        for (int c = 0; c < N_BTN; c++) begin
            if (pif.btn_pulse[c] === 1'b1) begin
                pulse_seen[c]++;
                if (first_pulse[c] < 0) first_pulse[c] = cyc;
            end
        end
    endtask

    task automatic press(input logic [N_BTN-1:0] mask, input int hold, input int gap);
        repeat (hold) cycle(mask);
        repeat (gap) cycle('0);
    endtask

    task automatic do_reset(input int n);
        pif.button   = '0;
        pif.halt_req = 1'b0;
        halt_v       = 1'b0;
        resetn       = 1'b0;
        #1;
        check("rst_led_idle", 32'(pif.led_idle), 32'd1);
        check("rst_cpu_en", 32'(pif.cpu_en), 32'd0);
        check("rst_run_status", 32'(pif.led_run_status), 32'd0);
        check("rst_run_step", 32'(pif.led_run_step), 32'd0);
        check("rst_btn_pulse", 32'(pif.btn_pulse), 32'd0);
        repeat (n) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        int en0;
        int n;
        logic [N_BTN-1:0] mask;
        n_checks     = 0;
        n_errors     = 0;
        en_cycles    = 0;
        cyc          = 0;
        halt_v       = 1'b0;
        pif.button   = '0;
        pif.halt_req = 1'b0;
        model_reset();
        clear_obs();
        #2;
        do_reset(5);

        // Debounce: a 10-cycle press is a glitch, a 20-cycle press is one step.
        clear_obs();
        en0 = en_cycles;
        press(N_BTN'(2), 10, 25);
        check("glitch_no_pulse", 32'(pulse_seen[1]), 32'd0);
        start = cyc + 1;
        press(N_BTN'(2), 20, 25);
        check("deb_pulse_count", 32'(pulse_seen[1]), 32'd1);
        check("deb_latency", 32'(first_pulse[1] - start), 32'(DEB_N + 1));
        check("step_en_cycles", 32'(en_cycles - en0), 32'd1);
        check("step_count", 32'(pif.led_run_step), 32'd1);

        press(N_BTN'(8), 20, 25);
        check("clear_step", 32'(pif.led_run_step), 32'd0);
`ifdef PANEL_CTRL_BURST_EN
        exp_q = '{4'd4, 4'd8, 4'd12, 4'd0};
        for (int i = 0; i < 4; i++) begin
            en0 = en_cycles;
            press(N_BTN'(4), 20, 25);
            check("burst_en_cycles", 32'(en_cycles - en0), 32'(BURST_LEN));
            check("burst_step", 32'(pif.led_run_step), 32'(exp_q.pop_front()));
            check("burst_idle", 32'(pif.led_idle), 32'd1);
        end
`else
        clear_obs();
        en0 = en_cycles;
        press(N_BTN'(4), 20, 25);
        check("nob_pulse2", 32'(pulse_seen[2]), 32'd1);
        check("nob_en_cycles", 32'(en_cycles - en0), 32'd0);
        check("nob_idle", 32'(pif.led_idle), 32'd1);
`endif

        // Run, then halt after 10 enabled cycles.
        press(N_BTN'(8), 20, 25);
        press(N_BTN'(1), 20, 0);
        n = 0;
        while (pif.led_run_step !== 4'd10 && n < 200) begin
            cycle('0);
            n++;
        end
        check("run_reach_10", 32'(n < 200), 32'd1);
        halt_v       = 1'b1;
        pif.halt_req = 1'b1;
        #1;
        check("halt_gates_en", 32'(pif.cpu_en), 32'd0);
        cycle('0);
        check("halt_idle", 32'(pif.led_idle), 32'd1);
        check("halt_step", 32'(pif.led_run_step), 32'd10);
        en0 = en_cycles;
        press(N_BTN'(1), 20, 25);
        check("halt_run_ignored", 32'(pif.led_idle), 32'd1);
        check("halt_no_en", 32'(en_cycles - en0), 32'd0);
        check("halt_step_kept", 32'(pif.led_run_step), 32'd10);
        halt_v = 1'b0;

        // Clear together with run while running.
        press(N_BTN'(1), 20, 25);
        check("run_active", 32'(pif.led_run_status), 32'd1);
        press(N_BTN'(9), 20, 25);
        check("clr_prio_idle", 32'(pif.led_idle), 32'd1);
        check("clr_prio_step", 32'(pif.led_run_step), 32'd0);

        // Asynchronous reset while the enable is active.
        mask = BURST_ON ? N_BTN'(4) : N_BTN'(1);
        press(mask, 18, 2);
        check("pre_reset_busy", 32'(pif.led_run_status), 32'd1);
        do_reset(3);

        // Random traffic, occasional halts and resets.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 6) mask = N_BTN'(1 << $urandom_range(0, N_BTN - 1));
            else mask = N_BTN'($urandom_range(0, (1 << N_BTN) - 1));
            halt_v = ($urandom_range(0, 5) == 0);
            press(mask, $urandom_range(1, 24), $urandom_range(0, 24));
            if ($urandom_range(0, 49) == 0) do_reset(2);
        end
        halt_v = 1'b0;
        press('0, 30, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
